// File: rtl/ctrl_pipe_if.sv
// Signal bundle between the ID/EX pipeline controller and the rest of the datapath.
// The slave modport is the controller's view; the master modport is the datapath's view.
interface ctrl_pipe_if;
    logic [15:0] id_ctrl;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        ex_taken;
    logic [15:0] ex_ctrl;
    logic [4:0]  ex_wreg;
    logic [3:0]  mem_ctrl;
    logic [4:0]  mem_wreg;
    logic        stall;
    logic        flush_ifid;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport slave (
        input  id_ctrl, id_rs, id_rt, id_rd, ex_taken,
        output ex_ctrl, ex_wreg, mem_ctrl, mem_wreg, stall, flush_ifid,
               state, stall_cnt, flush_cnt
    );

    modport master (
        output id_ctrl, id_rs, id_rt, id_rd, ex_taken,
        input  ex_ctrl, ex_wreg, mem_ctrl, mem_wreg, stall, flush_ifid,
               state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ctrl_pipe.sv
// ID/EX/MEM control pipeline with load-use stall, taken-branch double flush,
// jump single flush and saturating stall/flush event counters.
module ctrl_pipe (
    input  logic         clk,
    input  logic         rst_n,
    ctrl_pipe_if.slave   bus
);
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_ex_ctrl;
    logic [15:0] w_ex_ctrl_next;
    logic [4:0]  r_ex_wreg;
    logic [4:0]  w_ex_wreg_next;
    logic [3:0]  r_mem_ctrl;
    logic [4:0]  r_mem_wreg;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_stall;
    logic        w_flush;
    logic [4:0]  w_id_wreg;
    logic        w_taken;
    logic        w_load_use;
    logic        w_id_jump;

    // jal always links into $31, regardless of RegDst
    assign w_id_wreg = (bus.id_ctrl[4:3] == 2'b11) ? 5'd31
                     : (bus.id_ctrl[10] ? bus.id_rt : bus.id_rd);

    assign w_taken    = r_ex_ctrl[11] & bus.ex_taken;
    assign w_load_use = r_ex_ctrl[13] && (r_ex_wreg != 5'd0) &&
                        ((r_ex_wreg == bus.id_rs) || (r_ex_wreg == bus.id_rt));
    assign w_id_jump  = bus.id_ctrl[2] | (bus.id_ctrl[4:3] != 2'b00);

    always_comb begin
        w_state_next   = RUN;
        w_ex_ctrl_next = 16'h0000;
        w_ex_wreg_next = 5'd0;
        w_stall        = 1'b0;
        w_flush        = 1'b0;
        case (r_state)
            RUN: begin
                if (w_taken) begin
                    w_flush      = 1'b1;
                    w_state_next = FLUSH;
                end else if (w_load_use) begin
                    w_stall      = 1'b1;
                    w_state_next = STALL;
                end else begin
                    w_flush        = w_id_jump;
                    w_ex_ctrl_next = bus.id_ctrl;
                    w_ex_wreg_next = w_id_wreg;
                end
            end
            // IF/ID was held last cycle, so the ID fields are the stalled instruction
            STALL: begin
                w_ex_ctrl_next = bus.id_ctrl;
                w_ex_wreg_next = w_id_wreg;
            end
            FLUSH: begin
                w_flush = 1'b1;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_ex_ctrl   <= 16'h0000;
            r_ex_wreg   <= 5'd0;
            r_mem_ctrl  <= 4'h0;
            r_mem_wreg  <= 5'd0;
            r_stall_cnt <= 16'h0000;
            r_flush_cnt <= 16'h0000;
        end else begin
            r_state    <= w_state_next;
            r_ex_ctrl  <= w_ex_ctrl_next;
            r_ex_wreg  <= w_ex_wreg_next;
            r_mem_ctrl <= r_ex_ctrl[15:12];
            r_mem_wreg <= r_ex_wreg;
            if (w_stall && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_flush && (r_flush_cnt != 16'hFFFF))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign bus.ex_ctrl    = r_ex_ctrl;
    assign bus.ex_wreg    = r_ex_wreg;
    assign bus.mem_ctrl   = r_mem_ctrl;
    assign bus.mem_wreg   = r_mem_wreg;
    assign bus.stall      = w_stall;
    assign bus.flush_ifid = w_flush;
    assign bus.state      = r_state;
    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.flush_cnt  = r_flush_cnt;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed hazard scenarios, a randomized run against an
// event-level reference model, counter saturation and asynchronous reset.
module tb_ctrl_pipe;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    ctrl_pipe_if bus ();

    ctrl_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [15:0] C_NOP  = 16'h0000;
    localparam logic [15:0] C_LW   = 16'hE420; // RegWrite MemToReg MemRead RegDst ALUSrc
    localparam logic [15:0] C_ADD  = 16'h8080; // RegWrite ALUOp=0010, dest = rd
    localparam logic [15:0] C_BEQ  = 16'h0840; // Branch ALUOp=0001
    localparam logic [15:0] C_LWBR = 16'hEC20; // MemRead and Branch together
    localparam logic [15:0] C_JAL  = 16'h801C; // RegWrite Jump=11 J_Jump
    localparam logic [15:0] C_J    = 16'h0004; // J_Jump only

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [15:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic tk);
        bus.id_ctrl  = c;
        bus.id_rs    = rs;
        bus.id_rt    = rt;
        bus.id_rd    = rd;
        bus.ex_taken = tk;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.ex_ctrl !== 16'h0) begin errors++; $display("FAIL reset_ex_ctrl got=%h exp=0000", bus.ex_ctrl); end
        checks++; if (bus.ex_wreg !== 5'd0) begin errors++; $display("FAIL reset_ex_wreg got=%0d exp=0", bus.ex_wreg); end
        checks++; if (bus.mem_ctrl !== 4'h0 || bus.mem_wreg !== 5'd0) begin errors++; $display("FAIL reset_mem got=%h/%0d exp=0/0", bus.mem_ctrl, bus.mem_wreg); end
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", bus.state); end
        checks++; if (bus.stall_cnt !== 16'h0 || bus.flush_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%h/%h exp=0/0", bus.stall_cnt, bus.flush_cnt); end
        checks++; if (bus.stall !== 1'b0 || bus.flush_ifid !== 1'b0) begin errors++; $display("FAIL reset_comb got=%b/%b exp=0/0", bus.stall, bus.flush_ifid); end
        $display("reset: outputs cleared while rst_n=0");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(C_LW, 5'd0, 5'd8, 5'd0, 1'b0);
        @(negedge clk);
        drive(C_ADD, 5'd8, 5'd1, 5'd9, 1'b0);
        #1;
        checks++; if (bus.stall !== 1'b1 || bus.flush_ifid !== 1'b0) begin errors++; $display("FAIL lu_stall got=%b/%b exp=1/0", bus.stall, bus.flush_ifid); end
        @(negedge clk);
        #1;
        checks++; if (bus.ex_ctrl !== 16'h0 || bus.ex_wreg !== 5'd0) begin errors++; $display("FAIL lu_bubble got=%h/%0d exp=0000/0", bus.ex_ctrl, bus.ex_wreg); end
        checks++; if (bus.state !== 2'b01 || bus.stall !== 1'b0) begin errors++; $display("FAIL lu_state got=%b stall=%b exp=01 stall=0", bus.state, bus.stall); end
        checks++; if (bus.mem_ctrl !== 4'hE || bus.mem_wreg !== 5'd8) begin errors++; $display("FAIL lu_mem got=%h/%0d exp=e/8", bus.mem_ctrl, bus.mem_wreg); end
        @(negedge clk);
        drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        checks++; if (bus.ex_ctrl !== C_ADD || bus.ex_wreg !== 5'd9) begin errors++; $display("FAIL lu_add got=%h/%0d exp=%h/9", bus.ex_ctrl, bus.ex_wreg, C_ADD); end
        checks++; if (bus.state !== 2'b00 || bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got=%b/%0d exp=00/1", bus.state, bus.stall_cnt); end
        $display("load_use: lw $8 then add rs=$8, stall_cnt=%0d", bus.stall_cnt);
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(C_LW, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        drive(C_ADD, 5'd0, 5'd0, 5'd3, 1'b0);
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL zero_stall got=%b exp=0", bus.stall); end
        @(negedge clk);
        #1;
        checks++; if (bus.state !== 2'b00 || bus.ex_ctrl !== C_ADD || bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL zero_run got=%b/%h/%0d exp=00/%h/0", bus.state, bus.ex_ctrl, bus.stall_cnt, C_ADD); end
        $display("zero_reg: lw $0 then add rs=$0, no stall");
    endtask

    task automatic test_taken_branch();
        do_reset();
        drive(C_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
        @(negedge clk);
        drive(C_ADD, 5'd1, 5'd2, 5'd3, 1'b1);
        #1;
        checks++; if (bus.flush_ifid !== 1'b1 || bus.stall !== 1'b0) begin errors++; $display("FAIL br_flush1 got=%b/%b exp=1/0", bus.flush_ifid, bus.stall); end
        @(negedge clk);
        #1;
        checks++; if (bus.flush_ifid !== 1'b1 || bus.state !== 2'b10 || bus.ex_ctrl !== 16'h0) begin errors++; $display("FAIL br_flush2 got=%b/%b/%h exp=1/10/0000", bus.flush_ifid, bus.state, bus.ex_ctrl); end
        @(negedge clk);
        drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        checks++; if (bus.flush_ifid !== 1'b0 || bus.state !== 2'b00 || bus.ex_ctrl !== 16'h0) begin errors++; $display("FAIL br_after got=%b/%b/%h exp=0/00/0000", bus.flush_ifid, bus.state, bus.ex_ctrl); end
        checks++; if (bus.flush_cnt !== 16'd2) begin errors++; $display("FAIL br_cnt got=%0d exp=2", bus.flush_cnt); end
        $display("taken_branch: beq taken, flush_cnt=%0d", bus.flush_cnt);
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive(C_LWBR, 5'd0, 5'd5, 5'd0, 1'b0);
        @(negedge clk);
        drive(C_ADD, 5'd5, 5'd0, 5'd6, 1'b1);
        #1;
        checks++; if (bus.flush_ifid !== 1'b1 || bus.stall !== 1'b0) begin errors++; $display("FAIL sim_comb got=%b/%b exp=1/0", bus.flush_ifid, bus.stall); end
        @(negedge clk);
        #1;
        checks++; if (bus.state !== 2'b10 || bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd1) begin errors++; $display("FAIL sim_state got=%b/%0d/%0d exp=10/0/1", bus.state, bus.stall_cnt, bus.flush_cnt); end
        $display("simultaneous: taken + load-use, flush path only");
    endtask

    task automatic test_jal();
        do_reset();
        drive(C_JAL, 5'd1, 5'd2, 5'd4, 1'b0);
        #1;
        checks++; if (bus.flush_ifid !== 1'b1 || bus.stall !== 1'b0) begin errors++; $display("FAIL jal_flush got=%b/%b exp=1/0", bus.flush_ifid, bus.stall); end
        @(negedge clk);
        drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        checks++; if (bus.ex_wreg !== 5'd31 || bus.ex_ctrl !== C_JAL) begin errors++; $display("FAIL jal_ex got=%h/%0d exp=%h/31", bus.ex_ctrl, bus.ex_wreg, C_JAL); end
        checks++; if (bus.state !== 2'b00 || bus.flush_ifid !== 1'b0 || bus.flush_cnt !== 16'd1) begin errors++; $display("FAIL jal_after got=%b/%b/%0d exp=00/0/1", bus.state, bus.flush_ifid, bus.flush_cnt); end
        $display("jal: ex_wreg=%0d flush_cnt=%0d", bus.ex_wreg, bus.flush_cnt);
    endtask

    // Reference model: tracks the pending pipeline event (none, one bubble owed,
    // one squash owed) and what each stage should hold.
    task automatic test_random();
        logic [15:0] m_ex_ctrl, m_mem_ctrl16, c;
        logic [4:0]  m_ex_wreg, m_mem_wreg, rs, rt, rd, dest;
        int          pending; // 0 none, 1 stall just issued, 2 second squash owed
        int          m_sc, m_fc;
        logic        tk, exp_stall, exp_flush, taken, hazard, jump;
        do_reset();
        m_ex_ctrl = 0; m_mem_ctrl16 = 0; m_ex_wreg = 0; m_mem_wreg = 0;
        pending = 0; m_sc = 0; m_fc = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            c = 16'($urandom) & 16'hFFFC;
            if ($urandom_range(0, 4) != 0) c[4:2] = 3'b000;
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 3));
            tk = 1'($urandom);
            drive(c, rs, rt, rd, tk);
            #1;
            if (c[4:3] == 2'd3) dest = 5'd31; else if (c[10]) dest = rt; else dest = rd;
            taken  = m_ex_ctrl[11] && tk;
            hazard = m_ex_ctrl[13] && m_ex_wreg != 0 && (m_ex_wreg == rs || m_ex_wreg == rt);
            jump   = c[2] || c[4:3] != 0;
            exp_stall = (pending == 0) && !taken && hazard;
            exp_flush = (pending == 2) || ((pending == 0) && (taken || (!hazard && jump)));
            checks++; if (bus.stall !== exp_stall || bus.flush_ifid !== exp_flush) begin errors++; $display("FAIL rnd_comb n=%0d got=%b/%b exp=%b/%b", n, bus.stall, bus.flush_ifid, exp_stall, exp_flush); end
            checks++; if (bus.state !== 2'(pending)) begin errors++; $display("FAIL rnd_state n=%0d got=%b exp=%0d", n, bus.state, pending); end
            checks++; if (bus.ex_ctrl !== m_ex_ctrl || bus.ex_wreg !== m_ex_wreg) begin errors++; $display("FAIL rnd_ex n=%0d got=%h/%0d exp=%h/%0d", n, bus.ex_ctrl, bus.ex_wreg, m_ex_ctrl, m_ex_wreg); end
            checks++; if (bus.mem_ctrl !== m_mem_ctrl16[15:12] || bus.mem_wreg !== m_mem_wreg) begin errors++; $display("FAIL rnd_mem n=%0d got=%h/%0d exp=%h/%0d", n, bus.mem_ctrl, bus.mem_wreg, m_mem_ctrl16[15:12], m_mem_wreg); end
            checks++; if (bus.stall_cnt !== 16'(m_sc) || bus.flush_cnt !== 16'(m_fc)) begin errors++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, bus.stall_cnt, bus.flush_cnt, m_sc, m_fc); end
            $display("rnd %0d: id=%h rs=%0d rt=%0d tk=%b stall=%b flush=%b", n, c, rs, rt, tk, bus.stall, bus.flush_ifid);
            m_mem_ctrl16 = m_ex_ctrl;
            m_mem_wreg   = m_ex_wreg;
            if (exp_stall && m_sc < 65535) m_sc++;
            if (exp_flush && m_fc < 65535) m_fc++;
            if (pending == 1 || (pending == 0 && !taken && !hazard)) begin
                m_ex_ctrl = c; m_ex_wreg = dest;
            end else begin
                m_ex_ctrl = 0; m_ex_wreg = 0;
            end
            pending = (pending != 0) ? 0 : (taken ? 2 : (hazard ? 1 : 0));
        end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(C_J, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (65535) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.flush_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got=%h exp=ffff", bus.flush_cnt); end
        checks++; if (bus.flush_ifid !== 1'b1) begin errors++; $display("FAIL sat_flush got=%b exp=1", bus.flush_ifid); end
        @(negedge clk);
        #1;
        checks++; if (bus.flush_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", bus.flush_cnt); end
        $display("saturation: flush_cnt=%h after 65536 jumps", bus.flush_cnt);
    endtask

    task automatic test_reset_mid_flush();
        @(negedge clk);
        drive(C_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
        @(negedge clk);
        drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b1);
        @(negedge clk);
        drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL rstf_pre got=%b exp=10", bus.state); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.state !== 2'b00 || bus.flush_ifid !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL rstf_state got=%b/%b/%b exp=00/0/0", bus.state, bus.flush_ifid, bus.stall); end
        checks++; if (bus.flush_cnt !== 16'h0 || bus.stall_cnt !== 16'h0 || bus.ex_ctrl !== 16'h0 || bus.mem_ctrl !== 4'h0 || bus.mem_wreg !== 5'd0) begin errors++; $display("FAIL rstf_regs got=%h/%h/%h/%h/%0d exp=0", bus.flush_cnt, bus.stall_cnt, bus.ex_ctrl, bus.mem_ctrl, bus.mem_wreg); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.flush_ifid !== 1'b0 || bus.state !== 2'b00 || bus.flush_cnt !== 16'h0) begin errors++; $display("FAIL rstf_after got=%b/%b/%h exp=0/00/0", bus.flush_ifid, bus.state, bus.flush_cnt); end
        $display("reset_mid_flush: flush abandoned, counters cleared");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        test_reset();
        test_load_use();
        test_zero_reg();
        test_taken_branch();
        test_simultaneous();
        test_jal();
        test_random();
        test_saturation();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have one clock and an active-low reset, asynchronous, named clk and rst_n, listed first.
REQ-002 SHALL have `clk  in  1  rising-edge clock for all state`.
REQ-003 SHALL have `rst_n  in  1  asynchronous active-low reset`.
REQ-004 SHALL have `id_ctrl  in  16  ID-stage decoded control`, packed MSB→LSB as {RegWrite, MemToReg, MemRead, MemWrite, Branch, RegDst, ALUOp[3:0], ALUSrc, Jump[1:0], J_Jump, 2'b00}.
REQ-005 SHALL have `id_rs, id_rt, id_rd  in  5 each  ID-stage register fields`.
REQ-006 SHALL have `ex_taken  in  1  EX branch-condition result`, only meaningful when ex_ctrl Branch=1.
REQ-007 SHALL have `ex_ctrl  out  16  registered ID/EX control, same packing`.
REQ-008 SHALL have `ex_wreg  out  5  registered EX destination register`.
REQ-009 SHALL have `mem_ctrl  out  4  registered EX/MEM {RegWrite, MemToReg, MemRead, MemWrite}`.
REQ-010 SHALL have `mem_wreg  out  5  registered MEM destination register`.
REQ-011 SHALL have `stall  out  1  combinational`; holds PC and IF/ID.
REQ-012 SHALL have `flush_ifid  out  1  combinational`; zeroes IF/ID.
REQ-013 SHALL have `state  out  2  FSM state`, encoded RUN=00, STALL=01, FLUSH=10.
REQ-014 SHALL have `stall_cnt, flush_cnt  out  16 each  saturating event counters`.

Function
REQ-015 SHALL compute the ID destination register id_wreg as follows:
- 31 when Jump==2'b11 (jal).
- Otherwise id_rt when RegDst=1.
- Otherwise id_rd.
REQ-016 SHALL detect a load-use hazard when all of the following hold:
- ex_ctrl MemRead=1.
- ex_wreg≠0.
- ex_wreg==id_rs, or ex_wreg==id_rt.
REQ-017 SHALL define taken as ex_ctrl Branch=1 AND ex_taken=1.
REQ-018 SHALL define id_jump as id J_Jump=1 OR id Jump≠00.
REQ-019 SHALL apply this priority in RUN: taken > load-use > id_jump > normal.
REQ-020 In RUN with taken:
- flush_ifid=1 and stall=0.
- At the next edge, ex_ctrl and ex_wreg load 0.
- state goes to FLUSH.
- flush_cnt increments.
REQ-021 In RUN with load-use (not taken):
- stall=1 and flush_ifid=0.
- At the next edge, ex_ctrl and ex_wreg load 0 (bubble).
- state goes to STALL.
- stall_cnt increments.
REQ-022 In RUN with id_jump only:
- flush_ifid=1 and stall=0.
- At the next edge, ex_ctrl loads id_ctrl.
- state remains RUN.
- flush_cnt increments.
REQ-023 In RUN with no event, ex_ctrl/ex_wreg SHALL load id_ctrl/id_wreg at the next edge.
REQ-024 In STALL:
- stall=0 and flush_ifid=0.
- ex_ctrl/ex_wreg load the held ID instruction.
- state returns to RUN.
- Hazard detection is not re-evaluated this cycle, so there is exactly one bubble per load-use.
REQ-025 In FLUSH (wrong-path squash slot 2):
- flush_ifid=1 and stall=0.
- ex_ctrl/ex_wreg load 0.
- state returns to RUN.
- flush_cnt increments.
- id_jump and load-use are ignored.
REQ-026 SHALL advance mem_ctrl/mem_wreg every edge from ex_ctrl[15:12]/ex_wreg, regardless of state.
REQ-027 SHALL make stall and flush_ifid mutually exclusive every cycle.
REQ-028 SHALL saturate counters at 16'hFFFF, with no wrap.
REQ-029 SHALL never enter state 11; if it occurs, the next edge goes to RUN with ex_ctrl=0.

Reset
REQ-030 While rst_n=0, SHALL immediately and asynchronously clear all registered outputs:
- ex_ctrl, ex_wreg, mem_ctrl, mem_wreg to 0.
- state to RUN.
- Both counters to 0.
REQ-031 Reset deassertion SHALL take effect at the first rising clk edge with rst_n=1.
REQ-032 Reset mid-STALL or mid-FLUSH SHALL abandon the operation.
REQ-033 Reset SHALL leave counters at 0 and SHALL NOT produce residual stall/flush after release.

Verification
REQ-034 SHALL cover the load-use scenario:
- Stimulus: lw to $8 in EX (MemRead=1, ex_wreg=8), then ID add with id_rs=8.
- Response: stall=1 for 1 cycle, ex_ctrl=0 the next cycle, then the add loads; stall_cnt=1.
REQ-035 SHALL cover the $0 case:
- Stimulus: lw with ex_wreg=0, id_rs=0.
- Response: no stall; state stays RUN.
REQ-036 SHALL cover the taken-branch scenario:
- Stimulus: beq in EX with ex_taken=1.
- Response: flush_ifid=1 for 2 consecutive cycles (RUN→FLUSH→RUN), ex_ctrl=0 for 2 cycles, flush_cnt=2.
REQ-037 SHALL cover simultaneous events:
- Stimulus: taken branch and load-use in the same cycle.
- Response: flush path only; stall=0, stall_cnt unchanged.
REQ-038 SHALL cover jal:
- Stimulus: ID jal (Jump=11, J_Jump=1).
- Response: ex_wreg=31 next cycle, flush_ifid=1 for one cycle, state stays RUN.
REQ-039 SHALL cover saturation and reset:
- Stimulus: flush_cnt preloaded to FFFF by repeated jumps, then another jump.
- Response: flush_cnt stays FFFF.
- Stimulus: rst_n pulse low mid-FLUSH.
- Response: all outputs 0 and state=RUN with no clk edge.
